// File: rtl/fpu_pkg.sv
// Shared types and constants for the FP issue sequencer and decoder.
package fpu_pkg;

    // Issue sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESOLVE,
        ST_EXEC,
        ST_DONE,
        ST_ILLEGAL
    } fpu_state_e;

    // Rounding-mode encodings.
    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;
    localparam logic [2:0] RM_DYN = 3'b111;

    // Exception flag bit positions within {NV,DZ,OF,UF,NX}.
    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

endpackage

// File: rtl/fpu_rm_resolve.sv
// Resolves an instruction rm field against the dynamic frm and flags
// any result that is not a real rounding mode.
module fpu_rm_resolve
    import fpu_pkg::*;
(
    input  logic [2:0] rm,
    input  logic [2:0] frm,
    output logic [2:0] rm_resolved,
    output logic       invalid
);

    // DYN defers to frm; 101/110/111 are never executable modes.
    assign rm_resolved = (rm == RM_DYN) ? frm : rm;
    assign invalid     = (rm_resolved == 3'b101) ||
                         (rm_resolved == 3'b110) ||
                         (rm_resolved == 3'b111);

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issue sequencer: accepts one decoded FP instruction, resolves its
// rounding mode, launches the arithmetic unit and waits under a watchdog.
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic       instr_legal,
    input  logic [2:0] instr_rm,
    input  logic [2:0] csr_frm,
    output logic       unit_start,
    output logic [2:0] unit_rm,
    input  logic       unit_done,
    input  logic [4:0] unit_flags,
    output logic       fpu_active,
    output logic       fpu_complete,
    output logic [4:0] S_flag,
    output logic       illegal_instr,
    output logic       timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    fpu_state_e       state_q, state_n;
    logic [2:0]       rm_q, rm_n;
    logic [2:0]       unit_rm_q, unit_rm_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [4:0]       s_flag_q, s_flag_n;
    logic             timeout_q, timeout_n;

    logic [2:0]       static_rm_unused;
    logic             static_invalid;
    logic [2:0]       dyn_rm;
    logic             dyn_invalid;

    // Static check: with frm tied to RNE, DYN always passes and only
    // the reserved encodings 101/110 are rejected.
    fpu_rm_resolve u_static_check (
        .rm          (instr_rm),
        .frm         (RM_RNE),
        .rm_resolved (static_rm_unused),
        .invalid     (static_invalid)
    );

    // Dynamic resolution against frm, used only in RESOLVE where frm is valid.
    fpu_rm_resolve u_dyn_resolve (
        .rm          (rm_q),
        .frm         (csr_frm),
        .rm_resolved (dyn_rm),
        .invalid     (dyn_invalid)
    );

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q   <= ST_IDLE;
            rm_q      <= RM_RNE;
            unit_rm_q <= RM_RNE;
            cnt_q     <= '0;
            s_flag_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples
            // pre-edge values regardless of statement order.
            state_q   <= state_n;
            rm_q      <= rm_n;
            unit_rm_q <= unit_rm_n;
            cnt_q     <= cnt_n;
            s_flag_q  <= s_flag_n;
            timeout_q <= timeout_n;
        end
    end

    // Next-state and next-register values; flags default to zero so they
    // are only nonzero in the cycle following the load, i.e. DONE.
    always_comb begin
        // NOTE: every target gets a default first so no path infers a latch.
        state_n   = state_q;
        rm_n      = rm_q;
        unit_rm_n = unit_rm_q;
        cnt_n     = cnt_q;
        s_flag_n  = '0;
        timeout_n = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    rm_n    = instr_rm;
                    state_n = (!instr_legal || static_invalid) ? ST_ILLEGAL : ST_RESOLVE;
                end
            end
            ST_RESOLVE: begin
                if (dyn_invalid) begin
                    state_n = ST_ILLEGAL;
                end else begin
                    unit_rm_n = dyn_rm;
                    cnt_n     = '0;
                    state_n   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (unit_done) begin
                    s_flag_n = unit_flags;
                    state_n  = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    s_flag_n[FLAG_NV] = 1'b1;
                    timeout_n         = 1'b1;
                    state_n           = ST_DONE;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE:    state_n = ST_IDLE;
            ST_ILLEGAL: state_n = ST_IDLE;
            default:    state_n = ST_IDLE;
        endcase
    end

    // Outputs are registers or pure decodes of the state register.
    assign instr_ready   = (state_q == ST_IDLE) && rst_l;
    assign unit_start    = (state_q == ST_EXEC) && (cnt_q == '0);
    assign unit_rm       = unit_rm_q;
    assign fpu_active    = (state_q == ST_RESOLVE) || (state_q == ST_EXEC) ||
                           (state_q == ST_DONE)    || (state_q == ST_ILLEGAL);
    assign fpu_complete  = (state_q == ST_DONE);
    assign S_flag        = s_flag_q;
    assign illegal_instr = (state_q == ST_ILLEGAL);
    assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl with a 4-cycle watchdog.
module tb_fpu_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst_l;
    logic       instr_valid;
    logic       instr_ready;
    logic       instr_legal;
    logic [2:0] instr_rm;
    logic [2:0] csr_frm;
    logic       unit_start;
    logic [2:0] unit_rm;
    logic       unit_done;
    logic [4:0] unit_flags;
    logic       fpu_active;
    logic       fpu_complete;
    logic [4:0] S_flag;
    logic       illegal_instr;
    logic       timeout_err;

    int errors = 0;
    int checks = 0;
    int xfers  = 0;
    int seen_complete;

    fpu_issue_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk           (clk),
        .rst_l         (rst_l),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_legal   (instr_legal),
        .instr_rm      (instr_rm),
        .csr_frm       (csr_frm),
        .unit_start    (unit_start),
        .unit_rm       (unit_rm),
        .unit_done     (unit_done),
        .unit_flags    (unit_flags),
        .fpu_active    (fpu_active),
        .fpu_complete  (fpu_complete),
        .S_flag        (S_flag),
        .illegal_instr (illegal_instr),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; outputs are checked and inputs driven at negedges.
    task automatic step();
        if (instr_valid && instr_ready) xfers++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic legal, input logic [2:0] rm);
        instr_valid = 1'b1;
        instr_legal = legal;
        instr_rm    = rm;
    endtask

    initial begin
        rst_l       = 1'b0;
        instr_valid = 1'b0;
        instr_legal = 1'b0;
        instr_rm    = 3'b000;
        csr_frm     = 3'b000;
        unit_done   = 1'b0;
        unit_flags  = 5'b00000;

        // Reset state
        @(negedge clk);
        check("rst_ready",   instr_ready,   0);
        check("rst_active",  fpu_active,    0);
        check("rst_start",   unit_start,    0);
        check("rst_unit_rm", unit_rm,       0);
        check("rst_sflag",   S_flag,        0);
        rst_l = 1'b1;
        #1;
        check("post_rst_ready", instr_ready, 1);

        // Legal rm=000, done in first EXEC cycle with NX
        issue(1'b1, 3'b000);
        step();                                   // cycle 1
        instr_valid = 1'b0;
        check("t1_c1_active", fpu_active,  1);
        check("t1_c1_ready",  instr_ready, 0);
        check("t1_c1_start",  unit_start,  0);
        step();                                   // cycle 2
        check("t1_c2_start",  unit_start,  1);
        check("t1_c2_rm",     unit_rm,     3'b000);
        unit_done  = 1'b1;
        unit_flags = 5'b00001;
        step();                                   // cycle 3
        unit_done = 1'b0;
        check("t1_c3_complete", fpu_complete, 1);
        check("t1_c3_sflag",    S_flag,       5'b00001);
        check("t1_c3_timeout",  timeout_err,  0);
        check("t1_c3_start",    unit_start,   0);
        step();                                   // cycle 4
        check("t1_c4_ready",    instr_ready,  1);
        check("t1_c4_sflag",    S_flag,       0);
        check("t1_c4_complete", fpu_complete, 0);

        // Dynamic rm=111 with frm=011
        issue(1'b1, 3'b111);
        csr_frm = 3'b011;
        step();
        instr_valid = 1'b0;
        step();                                   // cycle 2
        check("t2_start", unit_start, 1);
        check("t2_rm",    unit_rm,    3'b011);
        unit_done  = 1'b1;
        unit_flags = 5'b00100;
        step();
        unit_done = 1'b0;
        check("t2_sflag", S_flag, 5'b00100);
        step();

        // Dynamic rm=111 with frm=101 -> dynamic illegal
        issue(1'b1, 3'b111);
        csr_frm = 3'b101;
        step();                                   // cycle 1
        instr_valid = 1'b0;
        check("t3_c1_illegal", illegal_instr, 0);
        step();                                   // cycle 2
        check("t3_c2_illegal",  illegal_instr, 1);
        check("t3_c2_start",    unit_start,    0);
        check("t3_c2_complete", fpu_complete,  0);
        check("t3_c2_active",   fpu_active,    1);
        step();                                   // cycle 3
        check("t3_c3_ready",    instr_ready,   1);
        check("t3_c3_illegal",  illegal_instr, 0);
        csr_frm = 3'b000;

        // Static illegal: rm=110
        issue(1'b1, 3'b110);
        step();
        instr_valid = 1'b0;
        check("t4_illegal",  illegal_instr, 1);
        check("t4_active",   fpu_active,    1);
        check("t4_sflag",    S_flag,        0);
        check("t4_complete", fpu_complete,  0);
        step();
        check("t4_ready", instr_ready, 1);

        // Static illegal: decoder did not recognise opcode
        issue(1'b0, 3'b000);
        step();
        instr_valid = 1'b0;
        check("t5_illegal", illegal_instr, 1);
        step();
        check("t5_ready", instr_ready, 1);

        // Watchdog: no unit_done, TIMEOUT_CYCLES=4 -> DONE at cycle 6
        issue(1'b1, 3'b001);
        step();
        instr_valid = 1'b0;
        step();                                   // cycle 2
        check("t6_start", unit_start, 1);
        step(); step(); step();                   // cycle 5 (expiry)
        check("t6_c5_complete", fpu_complete, 0);
        check("t6_c5_active",   fpu_active,   1);
        check("t6_c5_start",    unit_start,   0);
        step();                                   // cycle 6
        check("t6_c6_complete", fpu_complete, 1);
        check("t6_c6_sflag",    S_flag,       5'b10000);
        check("t6_c6_timeout",  timeout_err,  1);
        step();                                   // cycle 7
        check("t6_c7_timeout",  timeout_err,  0);
        check("t6_c7_sflag",    S_flag,       0);
        check("t6_c7_ready",    instr_ready,  1);

        // unit_done on the expiry cycle wins
        issue(1'b1, 3'b100);
        step();
        instr_valid = 1'b0;
        step(); step(); step();                   // cycle 4
        check("t7_c4_complete", fpu_complete, 0);
        step();                                   // cycle 5
        unit_done  = 1'b1;
        unit_flags = 5'b01010;
        step();                                   // cycle 6
        unit_done = 1'b0;
        check("t7_complete", fpu_complete, 1);
        check("t7_sflag",    S_flag,       5'b01010);
        check("t7_timeout",  timeout_err,  0);
        check("t7_rm",       unit_rm,      3'b100);
        step();

        // Asynchronous reset in EXEC
        issue(1'b1, 3'b010);
        step();
        instr_valid = 1'b0;
        step();                                   // cycle 2, EXEC
        check("t8_rm_before", unit_rm, 3'b010);
        #2 rst_l = 1'b0;
        #1;
        check("t8_ready",    instr_ready,   0);
        check("t8_start",    unit_start,    0);
        check("t8_rm",       unit_rm,       0);
        check("t8_active",   fpu_active,    0);
        check("t8_complete", fpu_complete,  0);
        check("t8_sflag",    S_flag,        0);
        check("t8_illegal",  illegal_instr, 0);
        check("t8_timeout",  timeout_err,   0);
        @(negedge clk);
        rst_l = 1'b1;
        seen_complete = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (fpu_complete) seen_complete++;
        end
        check("t8_no_complete", seen_complete, 0);
        check("t8_idle_ready",  instr_ready,   1);
        issue(1'b1, 3'b011);
        step();
        instr_valid = 1'b0;
        step();
        check("t8_new_start", unit_start, 1);
        check("t8_new_rm",    unit_rm,    3'b011);
        unit_done  = 1'b1;
        unit_flags = 5'b00010;
        step();
        unit_done = 1'b0;
        check("t8_new_complete", fpu_complete, 1);
        check("t8_new_sflag",    S_flag,       5'b00010);
        step();

        // instr_valid held high; stray unit_done in IDLE
        xfers = 0;
        issue(1'b1, 3'b001);                      // cycle 0
        step();                                   // cycle 1
        step();                                   // cycle 2
        unit_done  = 1'b1;
        unit_flags = 5'b00001;
        step();                                   // cycle 3 DONE
        unit_done = 1'b0;
        check("t9_c3_complete", fpu_complete, 1);
        step();                                   // cycle 4 IDLE
        check("t9_c4_ready", instr_ready, 1);
        unit_done  = 1'b1;
        unit_flags = 5'b11111;
        step();                                   // cycle 5 RESOLVE
        unit_done   = 1'b0;
        instr_valid = 1'b0;
        check("t9_c5_complete", fpu_complete, 0);
        check("t9_c5_sflag",    S_flag,       0);
        check("t9_c5_active",   fpu_active,   1);
        step();                                   // cycle 6 EXEC
        check("t9_c6_start", unit_start, 1);
        unit_done  = 1'b1;
        unit_flags = 5'b01000;
        step();                                   // cycle 7 DONE
        unit_done = 1'b0;
        check("t9_c7_sflag", S_flag, 5'b01000);
        step();                                   // cycle 8
        check("t9_xfers", xfers, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
